jtcps2_keyfeed: RTL and testbench



---
 rtl/jtcps2_keyfeed.sv | 141 ++++++++++++++
 tb/tb_jtcps2_keyfeed.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jtcps2_keyfeed.sv
// Captures the 20-byte CPS2 key from the downloader stream and replays it as isolated din_we strobes.
// Build option: JTCPS2_KEYFEED_ZFILL_EN replays incomplete keys with missing bytes sent as 8'h00.
module jtcps2_keyfeed #(
    parameter int unsigned   AW        = 25,
    parameter logic [AW-1:0] KEY_START = '0,
    parameter int unsigned   GAP       = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          ioctl_wr,
    output logic [7:0]    din,
    output logic          din_we,
    output logic          busy,
    output logic          key_ok
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPLAY, S_DONE} state_t;

    localparam int unsigned NKEY    = 20;
    localparam logic [4:0]  LAST    = 5'd19;
    localparam logic [4:0]  END_IDX = 5'd20;
    localparam logic [3:0]  GAP_N   = 4'(GAP);

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_buf [NKEY];
    logic [NKEY-1:0] r_valid;
    logic [4:0]      r_idx, w_idx_nxt;
    logic [3:0]      r_gcnt, w_gcnt_nxt;
    logic            r_dl;
    logic [7:0]      r_din, w_din_nxt;
    logic            r_din_we, w_din_we_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_key_ok, w_key_ok_nxt;
    logic            w_rise, w_fall, w_go, w_in_win, w_capture;
    logic [AW-1:0]   w_off;
    logic [4:0]      w_rd_idx;
    logic [7:0]      w_rd_byte;

    assign w_rise    = downloading & ~r_dl;
    assign w_fall    = ~downloading & r_dl;
    // Wrapping subtraction makes addresses below KEY_START fall outside the window too
    assign w_off     = ioctl_addr - KEY_START;
    assign w_in_win  = w_off < AW'(NKEY);
    assign w_capture = ioctl_wr & w_in_win & (w_rise | (r_state == S_CAPTURE));

    // Next byte to present: byte 0 when leaving CAPTURE, else the one after the current strobe
    assign w_rd_idx  = (r_state == S_REPLAY && r_idx < LAST) ? r_idx + 5'd1 : '0;
`ifdef JTCPS2_KEYFEED_ZFILL_EN
    assign w_go      = 1'b1;
    assign w_rd_byte = r_valid[w_rd_idx] ? r_buf[w_rd_idx] : 8'h00;
`else
    assign w_go      = &r_valid;
    assign w_rd_byte = r_buf[w_rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            r_idx    <= '0;
            r_gcnt   <= '0;
            r_dl     <= 1'b0;
            r_din    <= '0;
            r_din_we <= 1'b0;
            r_busy   <= 1'b0;
            r_key_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_gcnt   <= w_gcnt_nxt;
            r_dl     <= downloading;
            r_din    <= w_din_nxt;
            r_din_we <= w_din_we_nxt;
            r_busy   <= w_busy_nxt;
            r_key_ok <= w_key_ok_nxt;
            if (w_rise)    r_valid <= '0;
            if (w_capture) r_valid[w_off[4:0]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) r_buf[w_off[4:0]] <= ioctl_dout;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_rise) begin
            w_state_nxt = S_CAPTURE;
        end else begin
            case (r_state)
                S_CAPTURE: if (w_fall) w_state_nxt = w_go ? S_REPLAY : S_IDLE;
                S_REPLAY:  if (r_gcnt == '0 && r_idx == END_IDX) w_state_nxt = S_DONE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_din_nxt    = r_din;
        w_din_we_nxt = 1'b0;
        w_busy_nxt   = r_busy;
        w_key_ok_nxt = r_key_ok;
        w_idx_nxt    = r_idx;
        w_gcnt_nxt   = r_gcnt;
        if (w_rise) begin
            w_busy_nxt   = 1'b0;
            w_key_ok_nxt = 1'b0;
        end else begin
            case (r_state)
                S_CAPTURE: if (w_fall && w_go) begin
                    w_busy_nxt = 1'b1;
                    w_idx_nxt  = '0;
                    w_gcnt_nxt = '0;
                    w_din_nxt  = w_rd_byte;
                end
                S_REPLAY: if (r_gcnt == '0) begin
                    // Index past the last byte means its gap has fully elapsed
                    if (r_idx == END_IDX) begin
                        w_busy_nxt   = 1'b0;
                        w_key_ok_nxt = 1'b1;
                    end else begin
                        w_din_we_nxt = 1'b1;
                        w_gcnt_nxt   = GAP_N;
                    end
                end else begin
                    w_gcnt_nxt = r_gcnt - 4'd1;
                    if (r_gcnt == GAP_N && r_idx < LAST) w_din_nxt = w_rd_byte;
                    if (r_gcnt == 4'd1) w_idx_nxt = r_idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign din    = r_din;
    assign din_we = r_din_we;
    assign busy   = r_busy;
    assign key_ok = r_key_ok;
endmodule

// File: tb/tb_jtcps2_keyfeed.sv
// Randomized self-checking bench for jtcps2_keyfeed against a per-cycle schedule model of the replay.
module tb_jtcps2_keyfeed;
    localparam int unsigned   AW  = 25;
    localparam logic [AW-1:0] KS  = 25'h100;
    localparam int unsigned   GAP = 2;
    localparam int            P   = GAP + 1;
`ifdef JTCPS2_KEYFEED_ZFILL_EN
    localparam bit ZFILL = 1'b1;
`else
    localparam bit ZFILL = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b1, downloading = 1'b0, ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic [7:0]    din;
    logic          din_we, busy, key_ok;

    int unsigned n_vec = 0, n_err = 0;
    int          cyc = 0;
    logic [7:0]  ref_buf [20];
    bit          ref_valid [20];

    jtcps2_keyfeed #(.AW(AW), .KEY_START(KS), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .din(din), .din_we(din_we), .busy(busy), .key_ok(key_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input logic [AW-1:0] addr, input logic [7:0] data);
        int off;
        off = int'(addr) - int'(KS);
        if (off >= 0 && off < 20) begin
            ref_buf[off]   = data;
            ref_valid[off] = 1'b1;
        end
    endtask

    task automatic start_dl(input bit with_wr, input logic [AW-1:0] addr, input logic [7:0] data);
        for (int i = 0; i < 20; i++) ref_valid[i] = 1'b0;
        downloading = 1'b1;
        if (with_wr) begin
            ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
            model_wr(addr, data);
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [7:0] data);
        ioctl_addr = addr; ioctl_dout = data; ioctl_wr = 1'b1;
        model_wr(addr, data);
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic end_dl(output int t0);
        downloading = 1'b0;
        tick();
        t0 = cyc;
    endtask

    task automatic wr_full_shuffled(input int skip_first);
        int order [20];
        int j, tmp;
        for (int i = 0; i < 20; i++) order[i] = i;
        for (int i = 19; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 20; i++)
            if (order[i] >= skip_first) wr(KS + AW'(order[i]), 8'($urandom));
    endtask

    // Strobe k expected at T+1+k*P; key_ok from T+1+20*P; busy over [T, T+1+20*P)
    task automatic observe(input int t0, input int abort_k, input int rst_k);
        bit         rep, ew;
        logic [7:0] exp_b [20];
        int         rel, k;
        rep = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_b[i] = ref_valid[i] ? ref_buf[i] : 8'h00;
            if (!ref_valid[i] && !ZFILL) rep = 1'b0;
        end
        for (int n = 0; n < 20 * P + 6; n++) begin
            @(negedge clk);
            rel = cyc - t0;
            ew  = rep && rel >= 1 && ((rel - 1) % P) == 0 && ((rel - 1) / P) < 20;
            k   = (rel - 1) / P;
            chk("din_we", 32'(din_we), 32'(ew));
            chk("busy", 32'(busy), 32'(rep && rel >= 0 && rel < 1 + 20 * P));
            chk("key_ok", 32'(key_ok), 32'(rep && rel >= 1 + 20 * P));
            if (rep && (rel % P) == 0 && (rel / P) < 20)
                chk("din_pre", 32'(din), 32'(exp_b[rel / P]));
            if (ew) begin
                chk("din", 32'(din), 32'(exp_b[k]));
                if (k == abort_k) begin
                    downloading = 1'b1;
                    @(negedge clk);
                    chk("abort_we", 32'(din_we), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_ok", 32'(key_ok), 32'd0);
                    for (int i = 0; i < 20; i++) ref_valid[i] = 1'b0;
                    return;
                end
                if (k == rst_k) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("rst_din", 32'(din), 32'd0);
                    chk("rst_we", 32'(din_we), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_ok", 32'(key_ok), 32'd0);
                    rst = 1'b0;
                    for (int i = 0; i < 20 * P; i++) begin
                        @(negedge clk);
                        chk("post_rst_we", 32'(din_we), 32'd0);
                        chk("post_rst_ok", 32'(key_ok), 32'd0);
                    end
                    return;
                end
            end
        end
    endtask

    initial begin
        int t0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_din", 32'(din), 32'd0);
        chk("reset_we", 32'(din_we), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ok", 32'(key_ok), 32'd0);
        rst = 1'b0;
        tick();

        // in-order key 8'h10..8'h23
        start_dl(1'b0, '0, '0);
        for (int i = 0; i < 20; i++) wr(KS + AW'(i), 8'h10 + 8'(i));
        end_dl(t0);
        observe(t0, -1, -1);

        // reverse arrival plus overwrite of byte 5
        start_dl(1'b0, '0, '0);
        for (int i = 19; i >= 0; i--) wr(KS + AW'(i), 8'($urandom));
        wr(KS + AW'(5), 8'hAA);
        end_dl(t0);
        observe(t0, -1, -1);

        // partial key: 12 bytes
        start_dl(1'b0, '0, '0);
        for (int i = 0; i < 12; i++) wr(KS + AW'(i), 8'($urandom));
        end_dl(t0);
        observe(t0, -1, -1);

        // just-outside-window writes must not complete a 19-byte key
        start_dl(1'b0, '0, '0);
        wr_full_shuffled(1);
        wr(KS - AW'(1), 8'hFF);
        wr(KS + AW'(20), 8'hFF);
        end_dl(t0);
        observe(t0, -1, -1);

        // full key with outside-window writes interleaved
        start_dl(1'b0, '0, '0);
        wr(KS - AW'(1), 8'hFF);
        wr_full_shuffled(0);
        wr(KS + AW'(20), 8'hFF);
        end_dl(t0);
        observe(t0, -1, -1);

        // new download aborts replay at strobe 7, then a full key replays from byte 0
        start_dl(1'b0, '0, '0);
        wr_full_shuffled(0);
        end_dl(t0);
        observe(t0, 7, -1);
        wr_full_shuffled(0);
        end_dl(t0);
        observe(t0, -1, -1);

        // reset mid-replay, then a download whose first write coincides with its start
        start_dl(1'b0, '0, '0);
        wr_full_shuffled(0);
        end_dl(t0);
        observe(t0, -1, 5);
        start_dl(1'b1, KS, 8'($urandom));
        wr_full_shuffled(1);
        end_dl(t0);
        observe(t0, -1, -1);

        // random mixes around the window edges
        for (int it = 0; it < 4; it++) begin
            start_dl(1'b0, '0, '0);
            if (it[0]) wr_full_shuffled(0);
            for (int n = $urandom_range(5, 25); n > 0; n--)
                wr(KS - AW'(2) + AW'($urandom_range(0, 23)), 8'($urandom));
            end_dl(t0);
            observe(t0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
